// File: rtl/eth_router_pkg.sv
// Shared types and helpers for the eth_frame_router slice: route code width,
// output FSM encoding and the saturating counter increment.
package eth_router_pkg;

  localparam int CNT_MAX_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } port_state_e;

  function automatic int sel_w(input int ch);
    return $clog2(ch + 1);
  endfunction

  // Any route code at or above this value leaves the output disabled.
  function automatic int route_off(input int ch);
    return ch;
  endfunction

  function automatic logic [CNT_MAX_W-1:0] sat_inc(
    input logic [CNT_MAX_W-1:0] cnt,
    input logic [1:0]           inc_by,
    input int                   cnt_w
  );
    logic [CNT_MAX_W:0] sum;
    logic [CNT_MAX_W:0] lim;
    sum = {1'b0, cnt} + {{(CNT_MAX_W-1){1'b0}}, inc_by};
    lim = ({{CNT_MAX_W{1'b0}}, 1'b1} << cnt_w) - {{CNT_MAX_W{1'b0}}, 1'b1};
    if (sum > lim) sum = lim;
    return sum[CNT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/eth_route_port.sv
// One TX output of the router: selects a source, locks onto it for the length
// of a frame and registers the forwarded beat (single-cycle latency).
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no frame open; route_sel followed, waiting for a source sof
// ST_PASS | frame open; source locked until eof, route_sel ignored
module eth_route_port
  import eth_router_pkg::*;
#(
  parameter int CH    = 4,
  parameter int DW    = 8,
  parameter int SEL_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [CH*DW-1:0]  rx_data_i,
  input  logic [CH-1:0]     rx_valid_i,
  input  logic [CH-1:0]     rx_sof_i,
  input  logic [CH-1:0]     rx_eof_i,
  input  logic [CH-1:0]     rx_fr_err_i,
  input  logic [SEL_W-1:0]  route_sel_i,
  output logic [DW-1:0]     tx_data_o,
  output logic              tx_valid_o,
  output logic              tx_sof_o,
  output logic              tx_eof_o,
  output logic              tx_fr_err_o,
  output logic              abort_o
);

  localparam logic [SEL_W-1:0] ROUTE_OFF = SEL_W'(route_off(CH));

  port_state_e      state_q, state_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [DW-1:0]    data_q, data_d;
  logic             valid_q, sof_q, eof_q, err_q, err_d;

  logic [SEL_W-1:0] cur_src;
  logic [DW-1:0]    s_data;
  logic             s_valid, s_sof, s_eof, s_err;
  logic             fwd, abort;

  assign cur_src = (state_q == ST_PASS) ? src_q : route_sel_i;

  always_comb begin
    s_data  = '0;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
    s_err   = 1'b0;
    if (cur_src < ROUTE_OFF) begin
      for (int k = 0; k < CH; k++) begin
        if (cur_src == SEL_W'(k)) begin
          s_data  = rx_data_i[k*DW +: DW];
          s_valid = rx_valid_i[k];
          s_sof   = rx_sof_i[k];
          s_eof   = rx_eof_i[k];
          s_err   = rx_fr_err_i[k];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    fwd     = 1'b0;
    abort   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_valid && s_sof) begin
          fwd     = 1'b1;
          err_d   = s_err;
          src_d   = route_sel_i;
          state_d = s_eof ? ST_IDLE : ST_PASS;
        end
      end
      ST_PASS: begin
        err_d = s_err;
        if (s_valid) begin
          fwd   = 1'b1;
          // A sof while a frame is open means the previous frame lost its eof.
          abort = s_sof;
          if (s_eof) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    data_d = fwd ? s_data : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      data_q  <= data_d;
      valid_q <= fwd;
      sof_q   <= fwd & s_sof;
      eof_q   <= fwd & s_eof;
      err_q   <= err_d;
    end
  end

  assign tx_data_o   = data_q;
  assign tx_valid_o  = valid_q;
  assign tx_sof_o    = sof_q;
  assign tx_eof_o    = eof_q;
  assign tx_fr_err_o = err_q;
  assign abort_o     = abort;

endmodule

// File: rtl/eth_frame_router.sv
// N-port MAC byte-stream router with frame-boundary route switching.
// Per-channel frame statistics are built only when ETH_ROUTER_STATS_EN is defined.
module eth_frame_router
  import eth_router_pkg::*;
#(
  parameter  int CH    = 4,
  parameter  int DW    = 8,
  parameter  int CNT_W = 16,
  localparam int SEL_W = $clog2(CH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [CH*DW-1:0]    rx_data_i,
  input  logic [CH-1:0]       rx_valid_i,
  input  logic [CH-1:0]       rx_sof_i,
  input  logic [CH-1:0]       rx_eof_i,
  input  logic [CH-1:0]       rx_fr_good_i,
  input  logic [CH-1:0]       rx_fr_err_i,
  input  logic [CH*SEL_W-1:0] route_sel_i,
  output logic [CH*DW-1:0]    tx_data_o,
  output logic [CH-1:0]       tx_valid_o,
  output logic [CH-1:0]       tx_sof_o,
  output logic [CH-1:0]       tx_eof_o,
  output logic [CH-1:0]       tx_fr_err_o,
  input  logic                cnt_clr_i,
  output logic [CH*CNT_W-1:0] rx_good_cnt_o,
  output logic [CH*CNT_W-1:0] rx_bad_cnt_o,
  output logic [CH*CNT_W-1:0] tx_abort_cnt_o
);

  logic [CH-1:0] abort;

  for (genvar k = 0; k < CH; k++) begin : g_port
    eth_route_port #(
      .CH   (CH),
      .DW   (DW),
      .SEL_W(SEL_W)
    ) u_port (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i),
      .rx_sof_i   (rx_sof_i),
      .rx_eof_i   (rx_eof_i),
      .rx_fr_err_i(rx_fr_err_i),
      .route_sel_i(route_sel_i[k*SEL_W +: SEL_W]),
      .tx_data_o  (tx_data_o[k*DW +: DW]),
      .tx_valid_o (tx_valid_o[k]),
      .tx_sof_o   (tx_sof_o[k]),
      .tx_eof_o   (tx_eof_o[k]),
      .tx_fr_err_o(tx_fr_err_o[k]),
      .abort_o    (abort[k])
    );
  end

`ifdef ETH_ROUTER_STATS_EN
  logic [CNT_W-1:0] good_q  [CH];
  logic [CNT_W-1:0] good_d  [CH];
  logic [CNT_W-1:0] bad_q   [CH];
  logic [CNT_W-1:0] bad_d   [CH];
  logic [CNT_W-1:0] abort_q [CH];
  logic [CNT_W-1:0] abort_d [CH];

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      good_d[k]  = '0;
      bad_d[k]   = '0;
      abort_d[k] = '0;
      if (!cnt_clr_i) begin
        good_d[k]  = CNT_W'(sat_inc(CNT_MAX_W'(good_q[k]),
                      {1'b0, rx_valid_i[k] & rx_eof_i[k] & rx_fr_good_i[k]}, CNT_W));
        // A bad eof and an fr_err pulse together count as two events.
        bad_d[k]   = CNT_W'(sat_inc(CNT_MAX_W'(bad_q[k]),
                      {1'b0, rx_valid_i[k] & rx_eof_i[k] & ~rx_fr_good_i[k]} +
                      {1'b0, rx_fr_err_i[k]}, CNT_W));
        abort_d[k] = CNT_W'(sat_inc(CNT_MAX_W'(abort_q[k]), {1'b0, abort[k]}, CNT_W));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < CH; k++) begin
      if (!rst_n_i) begin
        good_q[k]  <= '0;
        bad_q[k]   <= '0;
        abort_q[k] <= '0;
      end else begin
        good_q[k]  <= good_d[k];
        bad_q[k]   <= bad_d[k];
        abort_q[k] <= abort_d[k];
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_cnt_out
    assign rx_good_cnt_o[k*CNT_W +: CNT_W]  = good_q[k];
    assign rx_bad_cnt_o[k*CNT_W +: CNT_W]   = bad_q[k];
    assign tx_abort_cnt_o[k*CNT_W +: CNT_W] = abort_q[k];
  end
`else
  logic unused_ok;
  assign unused_ok      = ^{cnt_clr_i, rx_fr_good_i, abort};
  assign rx_good_cnt_o  = '0;
  assign rx_bad_cnt_o   = '0;
  assign tx_abort_cnt_o = '0;
`endif

endmodule

// File: tb/tb_eth_frame_router.sv
// Self-checking bench for eth_frame_router: table vectors plus frame sequences,
// with a reference model feeding an expected-output queue.
module tb_eth_frame_router;

  localparam int CH = 4;
  localparam int DW = 8;
`ifdef ETH_ROUTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] rx_data;
  logic [3:0]  rx_valid, rx_sof, rx_eof, rx_good, rx_err;
  logic [11:0] route_sel;
  logic        cnt_clr;

  logic [31:0] tx_data, tx4_data;
  logic [3:0]  tx_valid, tx_sof, tx_eof, tx_err;
  logic [3:0]  tx4_valid, tx4_sof, tx4_eof, tx4_err;
  logic [63:0] good_cnt, bad_cnt, abort_cnt;
  logic [15:0] good4_cnt, bad4_cnt, abort4_cnt;

  eth_frame_router #(.CH(CH), .DW(DW), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_sof_i(rx_sof), .rx_eof_i(rx_eof), .rx_fr_good_i(rx_good), .rx_fr_err_i(rx_err),
    .route_sel_i(route_sel), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
    .tx_sof_o(tx_sof), .tx_eof_o(tx_eof), .tx_fr_err_o(tx_err), .cnt_clr_i(cnt_clr),
    .rx_good_cnt_o(good_cnt), .rx_bad_cnt_o(bad_cnt), .tx_abort_cnt_o(abort_cnt)
  );

  eth_frame_router #(.CH(CH), .DW(DW), .CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_sof_i(rx_sof), .rx_eof_i(rx_eof), .rx_fr_good_i(rx_good), .rx_fr_err_i(rx_err),
    .route_sel_i(route_sel), .tx_data_o(tx4_data), .tx_valid_o(tx4_valid),
    .tx_sof_o(tx4_sof), .tx_eof_o(tx4_eof), .tx_fr_err_o(tx4_err), .cnt_clr_i(cnt_clr),
    .rx_good_cnt_o(good4_cnt), .rx_bad_cnt_o(bad4_cnt), .tx_abort_cnt_o(abort4_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  valid, sof, eof, err;
    logic [63:0] good, bad, abort;
    logic [15:0] good4, bad4, abort4;
  } exp_t;

  typedef struct {
    logic [11:0] sel;
    logic [3:0]  v, s, e, er;
    logic [3:0]  xv, xs, xe, xer;
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   beats[4];

  int        m_pass[4], m_lock[4];
  logic [7:0] m_data[4];
  int        m_good[4], m_bad[4], m_abort[4];
  int        m4_good[4], m4_bad[4], m4_abort[4];

  function automatic logic [11:0] mk_sel(input int s0, input int s1, input int s2, input int s3);
    return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  function automatic int sat(input int x, input int lim);
    return (x > lim) ? lim : x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: computes what the router must present after the next edge.
  task automatic model_step();
    exp_t x;
    int   ab[4];
    x = '0;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_pass[k] = 0; m_lock[k] = 0; m_data[k] = '0;
        m_good[k] = 0; m_bad[k] = 0; m_abort[k] = 0;
        m4_good[k] = 0; m4_bad[k] = 0; m4_abort[k] = 0;
      end
      exp_q.push_back(x);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      int cur;
      bit v, s, e, r, emit, er;
      cur = (m_pass[k] != 0) ? m_lock[k] : int'(route_sel[k*3 +: 3]);
      v = 0; s = 0; e = 0; r = 0; emit = 0; er = 0; ab[k] = 0;
      if (cur < 4) begin
        v = rx_valid[cur]; s = rx_sof[cur]; e = rx_eof[cur]; r = rx_err[cur];
      end
      if (m_pass[k] == 0) begin
        if (v && s) begin
          emit = 1; er = r; m_lock[k] = cur; m_pass[k] = e ? 0 : 1;
        end
      end else begin
        er = r;
        if (v) begin
          emit = 1;
          if (s) ab[k] = 1;
          if (e) m_pass[k] = 0;
        end
      end
      if (emit) m_data[k] = rx_data[cur*8 +: 8];
      x.data[k*8 +: 8] = m_data[k];
      x.valid[k] = emit;
      x.sof[k]   = emit & s;
      x.eof[k]   = emit & e;
      x.err[k]   = er;
    end
    for (int k = 0; k < 4; k++) begin
      int gi, bi;
      gi = (rx_valid[k] && rx_eof[k] && rx_good[k]) ? 1 : 0;
      bi = ((rx_valid[k] && rx_eof[k] && !rx_good[k]) ? 1 : 0) + (rx_err[k] ? 1 : 0);
      if (cnt_clr) begin
        m_good[k] = 0; m_bad[k] = 0; m_abort[k] = 0;
        m4_good[k] = 0; m4_bad[k] = 0; m4_abort[k] = 0;
      end else begin
        m_good[k]   = sat(m_good[k] + gi, 65535);
        m_bad[k]    = sat(m_bad[k] + bi, 65535);
        m_abort[k]  = sat(m_abort[k] + ab[k], 65535);
        m4_good[k]  = sat(m4_good[k] + gi, 15);
        m4_bad[k]   = sat(m4_bad[k] + bi, 15);
        m4_abort[k] = sat(m4_abort[k] + ab[k], 15);
      end
      if (STATS) begin
        x.good[k*16 +: 16]  = 16'(m_good[k]);
        x.bad[k*16 +: 16]   = 16'(m_bad[k]);
        x.abort[k*16 +: 16] = 16'(m_abort[k]);
        x.good4[k*4 +: 4]   = 4'(m4_good[k]);
        x.bad4[k*4 +: 4]    = 4'(m4_bad[k]);
        x.abort4[k*4 +: 4]  = 4'(m4_abort[k]);
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic cycle();
    exp_t x;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard: queue empty at %0t", $time);
      return;
    end
    x = exp_q.pop_front();
    chk("tx_data", 64'(tx_data), 64'(x.data));
    chk("tx_ctrl", 64'({tx_valid, tx_sof, tx_eof, tx_err}), 64'({x.valid, x.sof, x.eof, x.err}));
    chk("good_cnt", good_cnt, x.good);
    chk("bad_cnt", bad_cnt, x.bad);
    chk("abort_cnt", abort_cnt, x.abort);
    chk("cnt_w4", 64'({good4_cnt, bad4_cnt, abort4_cnt}), 64'({x.good4, x.bad4, x.abort4}));
    for (int k = 0; k < 4; k++) if (tx_valid[k]) beats[k]++;
  endtask

  task automatic idle_inputs();
    rx_valid = '0; rx_sof = '0; rx_eof = '0; rx_good = '0; rx_err = '0; cnt_clr = 1'b0;
  endtask

  task automatic beat(input int src, input bit s, input bit e, input bit g, input bit er);
    idle_inputs();
    rx_valid[src] = 1'b1;
    rx_sof[src]   = s;
    rx_eof[src]   = e;
    rx_good[src]  = e & g;
    rx_err[src]   = er;
    rx_data[src*8 +: 8] = 8'($urandom);
    cycle();
  endtask

  task automatic frame(input int src, input int len, input bit g, input bit err_at_eof);
    for (int i = 0; i < len; i++)
      beat(src, i == 0, i == len - 1, g, err_at_eof && (i == len - 1));
  endtask

  vec_t vecs[9];

  initial begin
    int b0[4];
    vecs[0] = '{mk_sel(3,3,3,3), 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
    vecs[1] = '{mk_sel(3,3,3,3), 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[2] = '{mk_sel(1,0,2,3), 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    vecs[3] = '{mk_sel(4,4,4,4), 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    vecs[4] = '{mk_sel(4,4,4,4), 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
    vecs[5] = '{mk_sel(4,4,4,4), 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[6] = '{mk_sel(0,0,0,0), 4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
    vecs[7] = '{mk_sel(0,1,2,3), 4'b1111, 4'b1111, 4'b0000, 4'b0101, 4'b1111, 4'b1111, 4'b0000, 4'b0101};
    vecs[8] = '{mk_sel(4,4,4,4), 4'b1111, 4'b0000, 4'b1111, 4'b0010, 4'b1111, 4'b0000, 4'b1111, 4'b0010};

    rst_n = 1'b0;
    rx_data = '0;
    route_sel = mk_sel(4,4,4,4);
    idle_inputs();
    for (int k = 0; k < 4; k++) beats[k] = 0;
    cycle();
    cycle();
    chk("reset_tx", 64'({tx_valid, tx_sof, tx_eof, tx_err, tx_data}), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Table vectors: routing, loopback, broadcast, disabled routes, fr_err gating.
    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      route_sel = vecs[i].sel;
      rx_valid  = vecs[i].v;
      rx_sof    = vecs[i].s;
      rx_eof    = vecs[i].e;
      rx_err    = vecs[i].er;
      rx_data   = $urandom;
      cycle();
      chk($sformatf("vec%0d_valid", i), 64'(tx_valid), 64'(vecs[i].xv));
      chk($sformatf("vec%0d_sof", i), 64'(tx_sof), 64'(vecs[i].xs));
      chk($sformatf("vec%0d_eof", i), 64'(tx_eof), 64'(vecs[i].xe));
      chk($sformatf("vec%0d_err", i), 64'(tx_err), 64'(vecs[i].xer));
    end

    // 64-byte frame src0 -> tx1 only.
    route_sel = mk_sel(1,0,2,3);
    b0 = beats;
    frame(0, 64, 1'b1, 1'b0);
    cycle();
    chk("t1_tx1_beats", 64'(beats[1] - b0[1]), 64'd64);
    chk("t1_other_beats", 64'(beats[0] + beats[2] + beats[3] - b0[0] - b0[2] - b0[3]), 64'd0);

    // Route change mid-frame takes effect only after eof.
    b0 = beats;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) route_sel = mk_sel(1,2,2,3);
      beat(0, i == 0, i == 19, 1'b1, 1'b0);
    end
    frame(2, 5, 1'b1, 1'b0);
    chk("t2_tx1_beats", 64'(beats[1] - b0[1]), 64'd25);
    b0 = beats;
    frame(0, 6, 1'b1, 1'b0);
    chk("t2_src0_ignored", 64'(beats[1] - b0[1]), 64'd0);

    // Missing eof: second sof restarts the frame and counts one abort.
    route_sel = mk_sel(1,0,2,3);
    for (int i = 0; i < 5; i++) beat(0, i == 0, 1'b0, 1'b0, 1'b0);
    beat(0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_second_sof", 64'(tx_sof[1]), 64'd1);
    for (int i = 0; i < 3; i++) beat(0, 1'b0, i == 2, 1'b1, 1'b0);
    chk("t4_abort_cnt", 64'(abort_cnt[31:16]), STATS ? 64'd1 : 64'd0);

    // Statistics on src2.
    idle_inputs();
    cnt_clr = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) frame(2, 4, 1'b1, 1'b0);
    frame(2, 3, 1'b0, 1'b0);
    frame(2, 3, 1'b0, 1'b1);
    chk("t5_good", 64'(good_cnt[47:32]), STATS ? 64'd3 : 64'd0);
    chk("t5_bad", 64'(bad_cnt[47:32]), STATS ? 64'd3 : 64'd0);
    for (int i = 0; i < 20; i++) frame(2, 1, 1'b1, 1'b0);
    chk("t5_good_w16", 64'(good_cnt[47:32]), STATS ? 64'd23 : 64'd0);
    chk("t5_good_sat", 64'(good4_cnt[11:8]), STATS ? 64'd15 : 64'd0);
    idle_inputs();
    cnt_clr = 1'b1;
    cycle();
    chk("t5_clr", 64'({good_cnt[47:32], bad_cnt[47:32], good4_cnt[11:8]}), 64'd0);

    // Reset at byte 7 of a routed frame.
    frame(2, 2, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) beat(0, i == 0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    beat(0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk("t6_rst_tx", 64'({tx_valid, tx_sof, tx_eof, tx_err, tx_data}), 64'd0);
    chk("t6_rst_cnt", good_cnt | bad_cnt | abort_cnt, 64'd0);
    b0 = beats;
    for (int i = 8; i < 13; i++) beat(0, 1'b0, i == 12, 1'b1, 1'b0);
    chk("t6_no_output", 64'(beats[1] - b0[1]), 64'd0);
    frame(0, 3, 1'b1, 1'b0);
    chk("t6_resume", 64'(beats[1] - b0[1]), 64'd3);

    idle_inputs();
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
